// File: rtl/arm_pkg.sv
// Shared pipeline definitions used by the write-back stage.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    WAIT = 2'd2
  } wb_state_t;

  // Register index of the program counter; it is never written by write-back.
  localparam int PC_IDX = 15;

endpackage

// File: rtl/wb_ret_counter.sv
// Retired-instruction counter: counts enable pulses, wraps at 2^DATA_W.
module wb_ret_counter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  output logic [DATA_W-1:0] count_o
);

  logic [DATA_W-1:0] cnt_q;

  // Count one per enabled cycle; natural overflow gives the wrap to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + DATA_W'(1);
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: captures instructions from MEM, waits for outstanding
// load data, and drives the register-file write port and retire count.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              freeze,
  input  logic              wb_en_in,
  input  logic              mem_r_in,
  input  logic [REG_AW-1:0] dst_in,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_rdy,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_dst,
  output logic [DATA_W-1:0] wb_val,
  output logic              stall_out,
  output logic              pend_ld,
  output logic [REG_AW-1:0] pend_dst,
  output logic [DATA_W-1:0] retired
);

  import arm_pkg::*;

  wb_state_t         state_q, state_d;
  logic              wen_q, wen_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              ret_en;

  // State and captured-instruction registers; reset abandons any pending load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      dst_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      dst_q   <= dst_d;
      val_q   <= val_d;
    end
  end

  // Next-state: capture from MEM in IDLE/WB, hold in WAIT until load data returns.
  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    dst_d   = dst_q;
    val_d   = val_q;
    ret_en  = 1'b0;
    case (state_q)
      WAIT: begin
        // MEM-side inputs are ignored here; only the returning data matters.
        if (mem_rdy) begin
          state_d = WB;
          val_d   = mem_data;
          ret_en  = 1'b1;
        end
      end
      default: begin
        if (valid_in && !freeze) begin
          wen_d = wb_en_in;
          dst_d = dst_in;
          if (mem_r_in && !mem_rdy) begin
            state_d = WAIT;
          end else begin
            state_d = WB;
            val_d   = mem_r_in ? mem_data : alu_res;
            ret_en  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  wb_ret_counter #(
    .DATA_W (DATA_W)
  ) u_ret (
    .clk     (clk),
    .rst     (rst),
    .en_i    (ret_en),
    .count_o (retired)
  );

  assign wb_en     = (state_q == WB) && wen_q && (dst_q != REG_AW'(PC_IDX));
  assign wb_dst    = dst_q;
  assign wb_val    = val_q;
  assign stall_out = (state_q == WAIT);
  assign pend_ld   = (state_q == WAIT);
  assign pend_dst  = (state_q == WAIT) ? dst_q : '0;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: DATA_W, 32, datapath and counter width.
REQ-002 Parameter: REG_AW, 4, register index width.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 valid_in  in  1  MEM stage presents an instruction this cycle.
REQ-006 freeze  in  1  pipeline freeze; blocks capture of valid_in.
REQ-007 wb_en_in  in  1  instruction writes a register.
REQ-008 mem_r_in  in  1  instruction is a load.
REQ-009 dst_in  in  REG_AW  destination register index.
REQ-010 alu_res  in  DATA_W  ALU result.
REQ-011 mem_data  in  DATA_W  load data, valid when mem_rdy=1.
REQ-012 mem_rdy  in  1  data memory returns load data this cycle.
REQ-013 wb_en  out  1  register-file write enable.
REQ-014 wb_dst  out  REG_AW  register-file write index.
REQ-015 wb_val  out  DATA_W  register-file write data.
REQ-016 stall_out  out  1  load pending; upstream holds its outputs.
REQ-017 pend_ld  out  1  load pending (hazard unit).
REQ-018 pend_dst  out  REG_AW  pending load destination (hazard unit).
REQ-019 retired  out  DATA_W  retired-instruction count.

Function
REQ-020 FSM states: IDLE (no write), WB (write outputs valid this cycle), WAIT (load data outstanding).
REQ-021 IDLE or WB, valid_in=1, freeze=0: capture wb_en_in, mem_r_in, dst_in; if mem_r_in=1 and mem_rdy=0 -> WAIT, else -> WB.
REQ-022 IDLE or WB, valid_in=0 or freeze=1: -> IDLE; nothing captured.
REQ-023 WAIT: mem_rdy=1 -> WB, latch mem_data; mem_rdy=0 -> stay WAIT; valid_in, freeze and all MEM-side inputs ignored.
REQ-024 wb_val in WB: load -> mem_data latched at capture or at WAIT exit; otherwise alu_res latched at capture.
REQ-025 Latency: non-load, or load with mem_rdy=1 at capture, reaches WB one cycle after the capture edge; stalled load reaches WB one cycle after the edge where mem_rdy=1.
REQ-026 wb_en = 1 only in WB, with captured wb_en_in=1 and captured dst != 15; exactly one cycle per instruction.
REQ-027 dst = 15 (PC) never writes; wb_en held 0; instruction still retires.
REQ-028 wb_dst, wb_val are registered and stable through the whole WB cycle; the register file samples them on the following negedge.
REQ-029 stall_out = pend_ld = 1 exactly while in WAIT; pend_dst = captured dst while in WAIT, else 0.
REQ-030 retired increments by 1 on each entry to WB, regardless of wb_en_in; wraps 2^DATA_W-1 -> 0.
REQ-031 Back-to-back: WB with a new valid capture -> WB next cycle; one write per cycle, no bubble.
REQ-032 mem_rdy in IDLE or WB without a captured load is ignored.

Reset
REQ-033 rst=1 forces, immediately and independent of clk: state IDLE; wb_en, wb_dst, wb_val, stall_out, pend_ld, pend_dst, retired = 0.
REQ-034 rst during WAIT abandons the load: no write, no retire; later mem_rdy is ignored.
REQ-035 First capture occurs on the first posedge after rst deasserts.

Structure
REQ-036 Shared package arm_pkg holds wb_state_t (IDLE, WB, WAIT) and constant PC_IDX = 15.
REQ-037 Retire counter is sub-module wb_ret_counter (enable, async reset, DATA_W wrap); all else is in wb_stage.

Verification
REQ-038 rst pulse during WB with wb_en=1 -> all outputs 0 within the same cycle, state IDLE, retired=0.
REQ-039 ALU op dst=3, alu_res=0x0000_00AA -> next cycle wb_en=1, wb_dst=3, wb_val=0xAA; retired=1.
REQ-040 Load dst=5, mem_rdy=0 for 3 cycles, then mem_rdy=1 with mem_data=0xDEAD_BEEF -> stall_out=1 and pend_dst=5 for 3 cycles; next cycle wb_en=1, wb_val=0xDEADBEEF.
REQ-041 Three back-to-back ALU ops to r1, r2, dst=15 -> wb_en pattern 1,1,0 on consecutive cycles; retired=3.
REQ-042 valid_in=1 with freeze=1 -> no WB, retired unchanged; rst asserted in WAIT, then mem_rdy=1 -> no write.
REQ-043 Preload retired=0xFFFF_FFFF by forcing, retire one instruction -> retired=0.
